// File: rtl/backprop_scheduler.sv
// Time-shares one backPropper datapath across every neuron of a layer:
// fetch weights, present them, write back the update, accumulate the error vector.
module backprop_scheduler #(
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  real              training_ratio,
  input  real              layer_dendrites [32],
  output logic             busy,
  output logic             done,
  output logic             mem_rd_req,
  output logic [IDX_W-1:0] mem_rd_idx,
  input  logic             mem_rd_valid,
  input  real              mem_rd_weights [33],
  input  real              mem_rd_axon,
  input  real              mem_rd_backprop,
  output logic             mem_wr_en,
  output logic [IDX_W-1:0] mem_wr_idx,
  output real              mem_wr_weights [33],
  input  logic             mem_wr_ready,
  output real              dp_dendrites [32],
  output real              dp_weights [33],
  output real              dp_axon,
  output real              dp_backprop,
  output real              dp_training_ratio,
  input  real              dp_backprop_change [32],
  input  real              dp_weights_new [33],
  output real              err_out [32],
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_COMPUTE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  real              ratio_q;
  real              dendrites_q [32];

  logic rd_accept;
  logic wr_accept;

  // Handshakes: a read completes on an edge where mem_rd_req and mem_rd_valid
  // are both high, a write where mem_wr_en and mem_wr_ready are both high;
  // request, index and write data stay constant until that edge.
  assign rd_accept = (state == S_FETCH) && mem_rd_valid;
  assign wr_accept = (state == S_WRITE) && mem_wr_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
          idx_nxt   = '0;
        end
      end
      S_FETCH: begin
        if (rd_accept) state_nxt = S_COMPUTE;
      end
      S_COMPUTE: state_nxt = S_WRITE;
      S_WRITE: begin
        if (wr_accept) begin
          if (idx == LAST_IDX) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_FETCH;
            idx_nxt   = idx + IDX_W'(1);
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_rd_req <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_rd_idx <= '0;
      mem_wr_idx <= '0;
    end else begin
      busy       <= (state_nxt == S_FETCH) || (state_nxt == S_COMPUTE) ||
                    (state_nxt == S_WRITE);
      done       <= (state_nxt == S_DONE);
      mem_rd_req <= (state_nxt == S_FETCH);
      mem_wr_en  <= (state_nxt == S_WRITE);
      mem_rd_idx <= idx_nxt;
      mem_wr_idx <= idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ratio_q           <= 0.0;
      dp_axon           <= 0.0;
      dp_backprop       <= 0.0;
      dp_training_ratio <= 0.0;
      for (int j = 0; j < 32; j++) begin
        dendrites_q[j]  <= 0.0;
        dp_dendrites[j] <= 0.0;
        err_out[j]      <= 0.0;
      end
      for (int j = 0; j < 33; j++) begin
        dp_weights[j]     <= 0.0;
        mem_wr_weights[j] <= 0.0;
      end
    end else begin
      if ((state == S_IDLE) && start) begin
        ratio_q <= training_ratio;
        for (int j = 0; j < 32; j++) begin
          dendrites_q[j] <= layer_dendrites[j];
          err_out[j]     <= 0.0;
        end
      end
      // The datapath inputs move only here, so they are quiet through COMPUTE and WRITE.
      if (rd_accept) begin
        dp_axon           <= mem_rd_axon;
        dp_backprop       <= mem_rd_backprop;
        dp_training_ratio <= ratio_q;
        for (int j = 0; j < 32; j++) dp_dendrites[j] <= dendrites_q[j];
        for (int j = 0; j < 33; j++) dp_weights[j] <= mem_rd_weights[j];
      end
      if (state == S_COMPUTE) begin
        for (int j = 0; j < 33; j++) mem_wr_weights[j] <= dp_weights_new[j];
        for (int j = 0; j < 32; j++) err_out[j] <= err_out[j] + dp_backprop_change[j];
      end
    end
  end

endmodule

// File: tb/tb_backprop_scheduler.sv
// Bench for backprop_scheduler: an 8-neuron instance with a stallable memory model
// and a 1-neuron instance, both driving a +1.0 datapath stub.
module tb_backprop_scheduler;

  localparam int N  = 8;
  localparam int IW = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 8-neuron instance
  logic          start;
  real           ratio;
  real           dend [32];
  logic          busy, done, rd_req, rd_valid, wr_en, wr_ready;
  logic [IW-1:0] rd_idx, wr_idx;
  real           rd_w [33];
  real           rd_axon, rd_bp;
  real           wr_w [33];
  real           dp_dend [32];
  real           dp_w [33];
  real           dp_axon, dp_bp, dp_ratio;
  real           dp_chg [32];
  real           dp_w_new [33];
  real           err [32];
  logic [2:0]    dbg_state;

  backprop_scheduler #(.NUM_NEURONS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .training_ratio(ratio),
    .layer_dendrites(dend), .busy(busy), .done(done),
    .mem_rd_req(rd_req), .mem_rd_idx(rd_idx), .mem_rd_valid(rd_valid),
    .mem_rd_weights(rd_w), .mem_rd_axon(rd_axon), .mem_rd_backprop(rd_bp),
    .mem_wr_en(wr_en), .mem_wr_idx(wr_idx), .mem_wr_weights(wr_w),
    .mem_wr_ready(wr_ready), .dp_dendrites(dp_dend), .dp_weights(dp_w),
    .dp_axon(dp_axon), .dp_backprop(dp_bp), .dp_training_ratio(dp_ratio),
    .dp_backprop_change(dp_chg), .dp_weights_new(dp_w_new), .err_out(err),
    .dbg_state(dbg_state)
  );

  // 1-neuron instance
  logic       s_start, s_busy, s_done, s_rd_req, s_wr_en;
  logic       s_rd_idx, s_wr_idx;
  logic       s_valid = 1'b1;
  logic       s_ready = 1'b1;
  real        s_ratio;
  real        s_dend [32];
  real        s_rd_w [33];
  real        s_rd_axon, s_rd_bp;
  real        s_wr_w [33];
  real        s_dp_dend [32];
  real        s_dp_w [33];
  real        s_dp_axon, s_dp_bp, s_dp_ratio;
  real        s_dp_chg [32];
  real        s_dp_w_new [33];
  real        s_err [32];
  logic [2:0] s_dbg_state;

  backprop_scheduler #(.NUM_NEURONS(1)) dut_single (
    .clk(clk), .rst_n(rst_n), .start(s_start), .training_ratio(s_ratio),
    .layer_dendrites(s_dend), .busy(s_busy), .done(s_done),
    .mem_rd_req(s_rd_req), .mem_rd_idx(s_rd_idx), .mem_rd_valid(s_valid),
    .mem_rd_weights(s_rd_w), .mem_rd_axon(s_rd_axon), .mem_rd_backprop(s_rd_bp),
    .mem_wr_en(s_wr_en), .mem_wr_idx(s_wr_idx), .mem_wr_weights(s_wr_w),
    .mem_wr_ready(s_ready), .dp_dendrites(s_dp_dend), .dp_weights(s_dp_w),
    .dp_axon(s_dp_axon), .dp_backprop(s_dp_bp), .dp_training_ratio(s_dp_ratio),
    .dp_backprop_change(s_dp_chg), .dp_weights_new(s_dp_w_new), .err_out(s_err),
    .dbg_state(s_dbg_state)
  );

  // memory models and datapath stubs
  always_comb begin
    for (int j = 0; j < 33; j++) begin
      rd_w[j]       = real'(rd_idx);
      dp_w_new[j]   = dp_w[j] + 1.0;
      s_rd_w[j]     = real'(s_rd_idx);
      s_dp_w_new[j] = s_dp_w[j] + 1.0;
    end
    for (int j = 0; j < 32; j++) begin
      dp_chg[j]   = 1.0;
      s_dp_chg[j] = 1.0;
    end
    rd_axon   = real'(rd_idx) * 0.5;
    rd_bp     = 2.0;
    s_rd_axon = 0.0;
    s_rd_bp   = 0.0;
  end

  logic stall_en = 1'b0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  assign rd_valid = !(stall_en && rd_idx == 3'd3) || (rd_cnt >= 2);
  assign wr_ready = !(stall_en && wr_idx == 3'd3) || (wr_cnt >= 3);

  always @(posedge clk) begin
    rd_cnt <= (rd_req && !rd_valid) ? rd_cnt + 1 : 0;
    wr_cnt <= (wr_en && !wr_ready) ? wr_cnt + 1 : 0;
  end

  // scoreboard
  int            n_cmp = 0;
  int            n_err = 0;
  logic [IW-1:0] exp_q [$];
  real           cur_ratio;
  real           cur_dend7;

  task automatic check(input string tag, input real obs, input real expv);
    n_cmp++;
    if (obs != expv) begin
      n_err++;
      $display("FAIL %s: got %f expected %f", tag, obs, expv);
    end
  endtask

  int            n_writes = 0;
  int            done_cnt = 0;
  logic          prev_rd_pend = 1'b0;
  logic          prev_wr_pend = 1'b0;
  logic [IW-1:0] prev_rd_idx;
  logic [IW-1:0] prev_wr_idx;
  real           prev_wr_w0;
  int            s_reads = 0;
  int            s_writes = 0;

  always @(negedge clk) begin
    logic [IW-1:0] e;
    if (rd_req && prev_rd_pend) check("rd_idx_hold", real'(rd_idx), real'(prev_rd_idx));
    if (wr_en && prev_wr_pend) begin
      check("wr_idx_hold", real'(wr_idx), real'(prev_wr_idx));
      check("wr_data_hold", wr_w[0], prev_wr_w0);
    end
    prev_rd_pend = rd_req && !rd_valid;
    prev_rd_idx  = rd_idx;
    prev_wr_pend = wr_en && !wr_ready;
    prev_wr_idx  = wr_idx;
    prev_wr_w0   = wr_w[0];
    if (busy) check("rd_wr_overlap", real'(rd_req && wr_en), 0.0);
    if (done) begin
      done_cnt++;
      check("busy_with_done", real'(busy), 0.0);
    end
    if (wr_en && wr_ready) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", real'(wr_idx), -1.0);
      end else begin
        e = exp_q.pop_front();
        check("wr_idx", real'(wr_idx), real'(e));
        check("wr_w0", wr_w[0], real'(e) + 1.0);
        check("wr_w32", wr_w[32], real'(e) + 1.0);
        check("dp_axon", dp_axon, real'(e) * 0.5);
        check("dp_ratio", dp_ratio, cur_ratio);
        check("dp_dend7", dp_dend[7], cur_dend7);
      end
    end
    if (s_rd_req && s_valid) s_reads++;
    if (s_wr_en && s_ready) begin
      s_writes++;
      check("s_wr_idx", real'(s_wr_idx), 0.0);
      check("s_wr_w0", s_wr_w[0], 1.0);
    end
  end

  // driver tasks
  task automatic set_inputs(input real r);
    ratio     = r;
    cur_ratio = r;
    for (int j = 0; j < 32; j++) dend[j] = real'(j) * 0.5;
    cur_dend7 = 3.5;
  endtask

  task automatic run_pass(input logic ign, input int exp_done);
    int d0, done_cyc;
    d0       = done_cnt;
    done_cyc = -1;
    for (int i = 0; i < N; i++) exp_q.push_back(IW'(i));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    ratio   = 99.0;
    dend[7] = 77.0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      start = ign && (cyc == 4 || cyc == 25);
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("done_cycle", real'(done_cyc), real'(exp_done));
    check("idle_after_done", real'(busy), 0.0);
    repeat (3) @(negedge clk);
    check("done_pulses", real'(done_cnt - d0), 1.0);
    check("exp_q_left", real'(exp_q.size()), 0.0);
    for (int j = 0; j < 32; j++) check("err_out", err[j], 8.0);
  endtask

  task automatic reset_mid_pass();
    int w0;
    for (int i = 0; i < N; i++) exp_q.push_back(IW'(i));
    w0 = n_writes;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (17) @(negedge clk);
    @(posedge clk);
    #1;
    check("mid_wr_en", real'(wr_en), 1.0);
    check("mid_wr_idx", real'(wr_idx), 5.0);
    rst_n = 1'b0;
    #1;
    check("rst_wr_en", real'(wr_en), 0.0);
    check("rst_rd_req", real'(rd_req), 0.0);
    check("rst_busy", real'(busy), 0.0);
    check("rst_wr_idx", real'(wr_idx), 0.0);
    check("rst_err", err[0], 0.0);
    check("rst_dp_w", dp_w[0], 0.0);
    check("rst_dp_axon", dp_axon, 0.0);
    check("rst_wr_w", wr_w[0], 0.0);
    repeat (3) @(negedge clk);
    check("writes_before_rst", real'(n_writes - w0), 5.0);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int s_done_cyc;
    rst_n   = 1'b0;
    start   = 1'b0;
    s_start = 1'b0;
    s_ratio = 0.0;
    for (int j = 0; j < 32; j++) s_dend[j] = 0.0;
    set_inputs(0.25);
    repeat (3) @(negedge clk);
    check("reset_busy", real'(busy), 0.0);
    check("reset_done", real'(done), 0.0);
    check("reset_rd_req", real'(rd_req), 0.0);
    check("reset_wr_en", real'(wr_en), 0.0);
    check("reset_rd_idx", real'(rd_idx), 0.0);
    check("reset_err", err[31], 0.0);
    check("reset_dp_w", dp_w[32], 0.0);
    check("reset_dp_ratio", dp_ratio, 0.0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // zero-wait pass, start ignored mid-pass and in DONE
    run_pass(1'b1, 25);
    // back-to-back pass with read/write stalls on neuron 3
    set_inputs(1.5);
    stall_en = 1'b1;
    run_pass(1'b0, 30);
    stall_en = 1'b0;
    // reset during WRITE of neuron 5, then a clean restart from idx 0
    set_inputs(0.75);
    reset_mid_pass();
    repeat (2) @(negedge clk);
    set_inputs(2.0);
    run_pass(1'b0, 25);

    // single-neuron instance
    s_done_cyc = -1;
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge clk);
      if (s_done) begin
        s_done_cyc = cyc;
        break;
      end
    end
    check("s_done_cycle", real'(s_done_cyc), 4.0);
    repeat (2) @(negedge clk);
    check("s_reads", real'(s_reads), 1.0);
    check("s_writes", real'(s_writes), 1.0);
    check("s_err0", s_err[0], 1.0);
    check("s_err31", s_err[31], 1.0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/backprop_scheduler.md
# backprop_scheduler

Sequencer that time-shares one `backPropper` datapath instance across all neurons of a layer during training. For each neuron it does four things in turn: fetches the neuron's 33 weights, axon value and backprop term from the layer weight store; presents them to the datapath; writes the updated weights back; accumulates the 32 per-input backprop changes into an error vector for the previous layer. It sits between the layer weight memory and the `backPropper` instance, and is started once per training step by the network controller.

## Interface
- `NUM_NEURONS`, 8, neurons in the layer; legal range 1..256.
- `IDX_W`, `$clog2(NUM_NEURONS)` with a minimum of 1, width of the neuron index.
- `clk` in, 1, single clock; all state updates on the rising edge.
- `rst_n` in, 1, asynchronous active-low reset.
- `start` in, 1, pulse requesting a layer pass; sampled only in IDLE.
- `training_ratio` in, real, latched on an accepted `start`.
- `layer_dendrites` in, real[31:0], layer inputs, latched on an accepted `start`.
- `busy` out, 1, high in FETCH, COMPUTE and WRITE.
- `done` out, 1, one-cycle pulse at the end of a pass.
- `mem_rd_req` out, 1, read request; `mem_rd_idx` out, IDX_W, neuron index.
- `mem_rd_valid` in, 1; `mem_rd_weights` in, real[32:0]; `mem_rd_axon` in, real; `mem_rd_backprop` in, real.
- `mem_wr_en` out, 1; `mem_wr_idx` out, IDX_W; `mem_wr_weights` out, real[32:0]; `mem_wr_ready` in, 1.
- `dp_dendrites` out, real[31:0]; `dp_weights` out, real[32:0]; `dp_axon`, `dp_backprop`, `dp_training_ratio` out, real. These connect to the `backPropper` inputs.
- `dp_backprop_change` in, real[31:0]; `dp_weights_new` in, real[32:0]. These come from the `backPropper` outputs.
- `err_out` out, real[31:0], per-input sum of `dp_backprop_change` over all neurons in the pass.

## Operation
- **States:** IDLE, FETCH, COMPUTE, WRITE, DONE. The state register, index counter and all outputs are registered.
- **Reset values:** state=IDLE, idx=0. `busy`, `done`, `mem_rd_req` and `mem_wr_en` are 0. All real outputs are 0.0, including `err_out` and every `dp_*` port. The index outputs are 0.
- **IDLE:**
  - `start`=1 latches `training_ratio` and `layer_dendrites`, clears idx, clears `err_out` to 0.0, and moves to FETCH.
  - `mem_rd_valid` is ignored in IDLE.
- **FETCH:**
  - `mem_rd_req`=1 with `mem_rd_idx`=idx, held stable until `mem_rd_valid`=1 is sampled.
  - In the accepting cycle, capture weights/axon/backprop into the `dp_*` registers and move to COMPUTE.
  - `mem_rd_req` drops on the next edge.
- **COMPUTE:** exactly one cycle, giving the combinational datapath a full cycle to settle. At the end of the cycle:
  - capture `dp_weights_new` into the `mem_wr_weights` register;
  - update `err_out[j] += dp_backprop_change[j]` for every j;
  - move to WRITE.
- **WRITE:**
  - `mem_wr_en`=1 with `mem_wr_idx`=idx, held stable with the data until `mem_wr_ready`=1 is sampled.
  - On acceptance: if idx==NUM_NEURONS-1, go to DONE; otherwise idx++ and go to FETCH.
- **DONE:** `done`=1 and `busy`=0 for one cycle, then IDLE.
- **`err_out`:** holds its value from DONE until the next accepted `start`.
- **`start` while not IDLE:** ignored, including in the DONE cycle.
- **Index range:** idx never wraps; it stops at NUM_NEURONS-1.
- **NUM_NEURONS=1:** a single FETCH/COMPUTE/WRITE, then DONE.
- **Reset mid-pass:** an asynchronous return to reset values. A pending read or write is dropped; the memory side sees `mem_rd_req` and `mem_wr_en` fall immediately. Weights already written stay written.
- **`dp_*` stability:** `dp_*` outputs hold their last values outside COMPUTE; they change only on a FETCH acceptance.
- **Arithmetic:** real addition in neuron-index order. No saturation or rounding is applied.

## Timing
- **Per-neuron cost:** 3 cycles with zero-wait memory (FETCH, COMPUTE and WRITE, one cycle each). Each read or write wait adds one cycle per cycle stalled.
- **Pass latency:** `start` is sampled at edge 0. The FETCH of neuron 0 occupies cycle 1. With zero wait, `done` is high in cycle 3·NUM_NEURONS+1.
- **`busy` and `done`:** `busy` is high from cycle 1 through the last WRITE cycle. `busy` and `done` are never high together.
- **Read handshake:** `mem_rd_valid` is sampled only while `mem_rd_req`=1. The memory may assert valid in the first request cycle.
- **Write handshake:** `mem_wr_ready` may be high before `mem_wr_en`; acceptance requires both high on the same edge.
- **Read/write overlap:** never both asserted; reads and writes never overlap.

## Test plan
Benches use a datapath stub with `dp_weights_new[j]=dp_weights[j]+1.0` and `dp_backprop_change[j]=1.0`.
- **Zero-wait pass:** reset, then `start` with NUM_NEURONS=8 and memory returning `weights[j]=idx`, with valid and ready tied high. Required: 8 writes with `mem_wr_weights[j]=idx+1.0`, idx 0..7 in order; `done` in cycle 25; `err_out[j]=8.0` for all j.
- **Stalls:** `mem_rd_valid` delayed 2 cycles and `mem_wr_ready` delayed 3 cycles on neuron 3. Required: `mem_rd_idx` and `mem_wr_weights` held stable throughout; `done` delayed by exactly 5 cycles; results unchanged.
- **Ignored `start`:** `start` pulsed in cycles 4 and 25 of a pass. Required: ignored; exactly one `done` pulse; `err_out` not cleared.
- **Back-to-back passes:** a second `start` after `done`. Required: `err_out` resets and again ends at 8.0, not 16.0.
- **Reset mid-pass:** `rst_n` pulled low during the WRITE of neuron 5. Required: all outputs at reset values immediately; no further writes; a new `start` restarts at idx 0.
- **Single neuron:** NUM_NEURONS=1. Required: one read, one write, `done` in cycle 4, `err_out[j]=1.0`.
